bank64k_arbiter: RTL and testbench

//  Shares one bank64k between three requesters: instruction (I), data (D) and control (C).
//  The bank has one read port and one write port, each steered by a 2-bit muxcode.

---
 rtl/bank64k_pkg.sv | 28 ++
 rtl/bank64k_arbiter_rr_arb3.sv | 28 ++
 rtl/bank64k_arbiter.sv | 123 ++++++++++++
 tb/tb_bank64k_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank64k_pkg.sv
// Shared types and helpers for the bank64k requester arbiter.
// Muxcode map and round-robin pointer arithmetic.
package bank64k_pkg;

    localparam int NREQ = 3;

    typedef enum logic [1:0] {
        MUX_I = 2'b00,
        MUX_D = 2'b01,
        MUX_C = 2'b10
    } bank_mux_t;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic bank_mux_t mux_of(input int k);
        bank_mux_t m;
        if (k == 0)
            m = MUX_I;
        else if (k == 1)
            m = MUX_D;
        else
            m = MUX_C;
        return m;
    endfunction

endpackage

// File: rtl/bank64k_arbiter_rr_arb3.sv
// Three-way round-robin arbiter, purely combinational.
// Priority runs ptr, ptr+1, ptr+2 (mod 3); ptr_nxt points past the winner.
module rr_arb3
    import bank64k_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       en_in,
    output logic [2:0] gnt,
    output logic [1:0] ptr_nxt
);

    logic [1:0] cand;

    always_comb begin
        gnt     = 3'b000;
        ptr_nxt = ptr;
        cand    = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (en_in && gnt == 3'b000 && req[cand]) begin
                gnt[cand] = 1'b1;
                ptr_nxt   = rr_next(cand);
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/bank64k_arbiter.sv
// Shares one bank64k read port and write port between I, D and C requesters,
// registers the winning commands and returns per-requester read-valid strobes.
module bank64k_arbiter
    import bank64k_pkg::*;
#(
    parameter int w      = 64,
    parameter int a      = 10,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       rd_req,
    input  logic [3*a-1:0]   rd_addr_in,
    output logic [2:0]       rd_gnt,
    output logic [2:0]       rd_vld,
    input  logic [2:0]       wr_req,
    input  logic [3*a-1:0]   wr_addr_in,
    input  logic [3*w-1:0]   wr_data_in,
    output logic [2:0]       wr_gnt,
    output logic             bk_rd_en,
    output logic [a-1:0]     bk_rd_addr,
    output logic [1:0]       bk_rd_muxcode,
    output logic             bk_wr_en,
    output logic [a-1:0]     bk_wr_addr,
    output logic [1:0]       bk_wr_muxcode,
    output logic [w-1:0]     bk_wri,
    output logic [w-1:0]     bk_wrd,
    output logic [w-1:0]     bk_wrc
);

    logic [1:0]  rd_ptr, rd_ptr_nxt;
    logic [1:0]  wr_ptr, wr_ptr_nxt;
    logic [2:0]  rd_cand;
    logic [a-1:0] rd_sel_addr, wr_sel_addr;
    logic [w-1:0] wr_sel_data;
    bank_mux_t   rd_code, wr_code;
    logic        coll;

    logic [RD_LAT:0]       pipe_v;
    logic [RD_LAT:0][1:0]  pipe_m;

    rr_arb3 u_rd_arb (
        .req     (rd_req),
        .ptr     (rd_ptr),
        .en_in   (!rst),
        .gnt     (rd_cand),
        .ptr_nxt (rd_ptr_nxt)
    );

    rr_arb3 u_wr_arb (
        .req     (wr_req),
        .ptr     (wr_ptr),
        .en_in   (!rst),
        .gnt     (wr_gnt),
        .ptr_nxt (wr_ptr_nxt)
    );

    always_comb begin
        rd_sel_addr = '0;
        wr_sel_addr = '0;
        wr_sel_data = '0;
        rd_code     = MUX_I;
        wr_code     = MUX_I;
        for (int k = 0; k < NREQ; k++) begin
            if (rd_cand[k]) begin
                rd_sel_addr = rd_addr_in[k*a +: a];
                rd_code     = mux_of(k);
            end
            if (wr_gnt[k]) begin
                wr_sel_addr = wr_addr_in[k*a +: a];
                wr_sel_data = wr_data_in[k*w +: w];
                wr_code     = mux_of(k);
            end
        end
    end

    // Same-address read/write: the write wins, the read retries next cycle.
    assign coll   = (|rd_cand) && (|wr_gnt) && (rd_sel_addr == wr_sel_addr);
    assign rd_gnt = coll ? 3'b000 : rd_cand;

    assign rd_vld = pipe_v[RD_LAT] ? (3'b001 << pipe_m[RD_LAT]) : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= 2'd0;
            wr_ptr        <= 2'd0;
            bk_rd_en      <= 1'b0;
            bk_rd_addr    <= '0;
            bk_rd_muxcode <= 2'b00;
            bk_wr_en      <= 1'b0;
            bk_wr_addr    <= '0;
            bk_wr_muxcode <= 2'b00;
            bk_wri        <= '0;
            bk_wrd        <= '0;
            bk_wrc        <= '0;
            pipe_v        <= '0;
            pipe_m        <= '0;
        end else begin
            rd_ptr   <= coll ? rd_ptr : rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            bk_rd_en <= |rd_gnt;
            bk_wr_en <= |wr_gnt;
            if (|rd_gnt) begin
                bk_rd_addr    <= rd_sel_addr;
                bk_rd_muxcode <= rd_code;
            end
            if (|wr_gnt) begin
                bk_wr_addr    <= wr_sel_addr;
                bk_wr_muxcode <= wr_code;
                // Only the winner's lane moves; the others keep their value.
                unique case (wr_code)
                    MUX_I:   bk_wri <= wr_sel_data;
                    MUX_D:   bk_wrd <= wr_sel_data;
                    MUX_C:   bk_wrc <= wr_sel_data;
                    default: ;
                endcase
            end
            pipe_v <= {pipe_v[RD_LAT-1:0], |rd_gnt};
            pipe_m <= {pipe_m[RD_LAT-1:0], rd_code};
        end
    end

endmodule

// File: tb/tb_bank64k_arbiter.sv
// Directed bench for bank64k_arbiter with a behavioural two-cycle bank.
// Expected values are hand-derived per scenario.
module tb_bank64k_arbiter;

    localparam int W = 64;
    localparam int A = 10;

    logic           clk;
    logic           rst;
    logic [2:0]     rd_req, rd_gnt, rd_vld;
    logic [2:0]     wr_req, wr_gnt;
    logic [3*A-1:0] rd_addr_in, wr_addr_in;
    logic [3*W-1:0] wr_data_in;
    logic           bk_rd_en, bk_wr_en;
    logic [A-1:0]   bk_rd_addr, bk_wr_addr;
    logic [1:0]     bk_rd_muxcode, bk_wr_muxcode;
    logic [W-1:0]   bk_wri, bk_wrd, bk_wrc;

    logic [W-1:0]   mem [1024];
    logic [W-1:0]   rd_s1, rd_word, lane;
    logic [W-1:0]   exp_mem [1024];

    int checks = 0;
    int errors = 0;
    int vcnt [3];

    bank64k_arbiter #(.w(W), .a(A), .RD_LAT(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req        (rd_req),
        .rd_addr_in    (rd_addr_in),
        .rd_gnt        (rd_gnt),
        .rd_vld        (rd_vld),
        .wr_req        (wr_req),
        .wr_addr_in    (wr_addr_in),
        .wr_data_in    (wr_data_in),
        .wr_gnt        (wr_gnt),
        .bk_rd_en      (bk_rd_en),
        .bk_rd_addr    (bk_rd_addr),
        .bk_rd_muxcode (bk_rd_muxcode),
        .bk_wr_en      (bk_wr_en),
        .bk_wr_addr    (bk_wr_addr),
        .bk_wr_muxcode (bk_wr_muxcode),
        .bk_wri        (bk_wri),
        .bk_wrd        (bk_wrd),
        .bk_wrc        (bk_wrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: write lane picked by muxcode, read data two cycles after rd_en sampled.
    always_comb begin
        lane = bk_wri;
        if (bk_wr_muxcode == 2'b01)
            lane = bk_wrd;
        else if (bk_wr_muxcode == 2'b10)
            lane = bk_wrc;
    end

    always @(posedge clk) begin
        if (bk_wr_en)
            mem[bk_wr_addr] <= lane;
        if (bk_rd_en)
            rd_s1 <= mem[bk_rd_addr];
        rd_word <= rd_s1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rd_req = 3'b000;
        wr_req = 3'b000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        rd_req     = 3'b000;
        wr_req     = 3'b000;
        rd_addr_in = '0;
        wr_addr_in = '0;
        wr_data_in = '0;
        tick();
        tick();
        rd_req = 3'b111;
        wr_req = 3'b111;
        #1;
        check("rst_rd_gnt", rd_gnt, 3'b000);
        check("rst_wr_gnt", wr_gnt, 3'b000);
        check("rst_rd_en", bk_rd_en, 1'b0);
        check("rst_wr_en", bk_wr_en, 1'b0);
        check("rst_rd_vld", rd_vld, 3'b000);
        do_reset();

        // 1: D write then D read of the same word
        wr_addr_in[A +: A] = 10'h055;
        wr_data_in[W +: W] = 64'hDEADBEEF_CAFEF00D;
        wr_req = 3'b010;
        #1 check("t1_wr_gnt", wr_gnt, 3'b010);
        tick();
        wr_req = 3'b000;
        check("t1_wr_en", bk_wr_en, 1'b1);
        check("t1_wr_mux", bk_wr_muxcode, 2'b01);
        check("t1_wr_addr", bk_wr_addr, 10'h055);
        check("t1_wrd", bk_wrd, 64'hDEADBEEF_CAFEF00D);
        check("t1_wri_quiet", bk_wri, 64'h0);
        tick();
        check("t1_wr_en_pulse", bk_wr_en, 1'b0);
        rd_addr_in[A +: A] = 10'h055;
        rd_req = 3'b010;
        #1 check("t1_rd_gnt", rd_gnt, 3'b010);
        tick();
        rd_req = 3'b000;
        check("t1_rd_mux", bk_rd_muxcode, 2'b01);
        check("t1_vld_g1", rd_vld, 3'b000);
        tick();
        check("t1_vld_g2", rd_vld, 3'b000);
        tick();
        check("t1_vld_g3", rd_vld, 3'b010);
        check("t1_rdd", rd_word, 64'hDEADBEEF_CAFEF00D);

        // 2: all three held for 9 cycles, reads and writes in parallel
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rd_addr_in[k*A +: A] = A'(10'h100 + k);
            wr_addr_in[k*A +: A] = A'(10'h200 + k);
            vcnt[k] = 0;
        end
        for (int c = 0; c < 13; c++) begin
            rd_req = (c < 9) ? 3'b111 : 3'b000;
            wr_req = (c < 9) ? 3'b111 : 3'b000;
            #1;
            check("t2_rd_gnt", rd_gnt, (c < 9) ? (3'b001 << (c % 3)) : 3'b000);
            check("t2_wr_gnt", wr_gnt, (c < 9) ? (3'b001 << (c % 3)) : 3'b000);
            check("t2_rd_en", bk_rd_en, (c >= 1 && c <= 9) ? 1'b1 : 1'b0);
            check("t2_vld", rd_vld,
                  (c >= 3 && c <= 11) ? (3'b001 << ((c - 3) % 3)) : 3'b000);
            for (int k = 0; k < 3; k++)
                if (rd_vld[k])
                    vcnt[k]++;
            tick();
        end
        check("t2_cnt_i", vcnt[0], 3);
        check("t2_cnt_d", vcnt[1], 3);
        check("t2_cnt_c", vcnt[2], 3);

        // 3: same-cycle collision at 0x3FF
        do_reset();
        wr_addr_in[0 +: A] = 10'h3FF;
        wr_data_in[0 +: W] = 64'h0123_4567_89AB_CDEF;
        rd_addr_in[2*A +: A] = 10'h3FF;
        wr_req = 3'b001;
        rd_req = 3'b100;
        #1;
        check("t3_wr_gnt", wr_gnt, 3'b001);
        check("t3_rd_gnt0", rd_gnt, 3'b000);
        tick();
        wr_req = 3'b000;
        #1 check("t3_rd_gnt1", rd_gnt, 3'b100);
        tick();
        rd_req = 3'b000;
        tick();
        tick();
        check("t3_vld", rd_vld, 3'b100);
        check("t3_rdc", rd_word, 64'h0123_4567_89AB_CDEF);

        // 4: full sweep per requester
        do_reset();
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < 1024; c++) begin
                exp_mem[c] = {$urandom, $urandom};
                wr_addr_in[m*A +: A] = A'(c);
                wr_data_in[m*W +: W] = exp_mem[c];
                wr_req = 3'(3'b001 << m);
                tick();
            end
            wr_req = 3'b000;
            tick();
            for (int c = 0; c < 1027; c++) begin
                rd_req = (c < 1024) ? 3'(3'b001 << m) : 3'b000;
                rd_addr_in[m*A +: A] = A'(c);
                #1;
                if (c >= 3) begin
                    check("t4_vld", rd_vld, 3'(3'b001 << m));
                    check("t4_data", rd_word, exp_mem[c-3]);
                end
                tick();
            end
        end

        // 5: reset one cycle after an I read grant
        rd_addr_in[0 +: A] = 10'h123;
        rd_req = 3'b001;
        #1 check("t5_gnt", rd_gnt, 3'b001);
        tick();
        rd_req = 3'b000;
        rst = 1'b1;
        #1;
        check("t5_rd_en", bk_rd_en, 1'b0);
        check("t5_rd_addr", bk_rd_addr, 10'h0);
        check("t5_wr_addr", bk_wr_addr, 10'h0);
        check("t5_wr_mux", bk_wr_muxcode, 2'b00);
        check("t5_wri", bk_wri, 64'h0);
        check("t5_wrd", bk_wrd, 64'h0);
        check("t5_wrc", bk_wrc, 64'h0);
        check("t5_vld0", rd_vld, 3'b000);
        rd_req = 3'b111;
        wr_req = 3'b111;
        #1;
        check("t5_rd_gnt_rst", rd_gnt, 3'b000);
        check("t5_wr_gnt_rst", wr_gnt, 3'b000);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_vld_rst", rd_vld, 3'b000);
        end
        rst = 1'b0;
        wr_req = 3'b000;
        #1 check("t5_first_i", rd_gnt, 3'b001);
        tick();
        rd_req = 3'b000;
        check("t5_vld_r1", rd_vld, 3'b000);
        tick();
        check("t5_vld_r2", rd_vld, 3'b000);
        tick();
        check("t5_vld_r3", rd_vld, 3'b001);

        // 6: D drops its request before ever winning
        do_reset();
        rd_addr_in[0 +: A]   = 10'h011;
        rd_addr_in[A +: A]   = 10'h022;
        rd_addr_in[2*A +: A] = 10'h033;
        rd_req = 3'b011;
        #1 check("t6_gnt_i", rd_gnt, 3'b001);
        tick();
        rd_req = 3'b000;
        #1;
        check("t6_gnt_none", rd_gnt, 3'b000);
        check("t6_en1", bk_rd_en, 1'b1);
        tick();
        rd_req = 3'b111;
        #1;
        check("t6_en0", bk_rd_en, 1'b0);
        check("t6_addr_hold", bk_rd_addr, 10'h011);
        check("t6_ptr_d", rd_gnt, 3'b010);
        tick();
        rd_req = 3'b000;
        check("t6_vld_i", rd_vld, 3'b001);
        tick();
        check("t6_vld_gap", rd_vld, 3'b000);
        tick();
        check("t6_vld_d", rd_vld, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
